// File: rtl/mips_mem_pkg.sv
// Shared definitions for the IF/MEM memory port arbiter: FSM state encoding,
// owner identifiers, the rdata value returned on a watchdog abort and the
// grant priority rule.
package mips_mem_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2
   } arb_state_t;

   typedef enum logic {
      OWNER_I = 1'b0,
      OWNER_D = 1'b1
   } owner_t;

   localparam int unsigned ABORT_RDATA = 0;

   // Data normally wins; a waiting fetch wins once the data streak is full.
   function automatic owner_t pick_owner(input logic if_req,
                                         input logic d_req,
                                         input logic streak_full);
      if (d_req && !(if_req && streak_full)) begin
         return OWNER_D;
      end
      return OWNER_I;
   endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// Ack watchdog for the memory port arbiter. Counts BUSY cycles without a
// memory ack and flags expiry when the count reaches ACK_TIMEOUT.
module mem_arb_watchdog #(
   parameter int ACK_TIMEOUT = 15
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic inc,
   output logic expired
);

   logic [7:0] count;

   // Cycle counter: cleared on every grant, advanced while waiting for an ack.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= 8'd0;
      end else if (clear) begin
         count <= 8'd0;
      end else if (inc && (count != 8'hFF)) begin
         count <= count + 8'd1;
      end
   end

   assign expired = (count == 8'(ACK_TIMEOUT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported, variable-latency memory between the pipeline's
// instruction-fetch port and its data port. Accesses are serialised, the
// pipeline stall is generated here, fetch starvation is bounded by a data
// streak counter, and a watchdog aborts accesses whose ack never arrives.
module mem_port_arbiter
   import mips_mem_pkg::*;
#(
   parameter int AW          = 32,
   parameter int DW          = 32,
   parameter int MAX_DSTREAK = 3,
   parameter int ACK_TIMEOUT = 15
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic [DW-1:0] if_rdata,
   output logic          if_ready,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic [DW-1:0] d_rdata,
   output logic          d_ready,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_ack,
   output logic          stall,
   output logic          err
);

   arb_state_t state;
   arb_state_t state_next;
   owner_t     grant_owner;
   logic       grant;
   logic       wd_clear;
   logic       wd_inc;
   logic       wd_expired;
   logic       set_err;
   logic [3:0] dstreak;
   logic       streak_full;

   assign streak_full = (dstreak >= 4'(MAX_DSTREAK));

   mem_arb_watchdog #(
      .ACK_TIMEOUT(ACK_TIMEOUT)
   ) u_watchdog (
      .clk    (clk),
      .reset  (reset),
      .clear  (wd_clear),
      .inc    (wd_inc),
      .expired(wd_expired)
   );

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Grant decision in IDLE; completion or abort of the owner's access in BUSY.
   always_comb begin
      state_next  = state;
      grant       = 1'b0;
      grant_owner = OWNER_I;
      wd_clear    = 1'b0;
      wd_inc      = 1'b0;
      set_err     = 1'b0;
      if_ready    = 1'b0;
      d_ready     = 1'b0;
      if_rdata    = '0;
      d_rdata     = '0;
      case (state)
         IDLE: begin
            if (if_req || d_req) begin
               grant       = 1'b1;
               grant_owner = pick_owner(if_req, d_req, streak_full);
               wd_clear    = 1'b1;
               state_next  = (grant_owner == OWNER_D) ? BUSY_D : BUSY_I;
            end
         end
         BUSY_I, BUSY_D: begin
            if (mem_ack || wd_expired) begin
               state_next = IDLE;
               set_err    = !mem_ack;
               if (state == BUSY_I) begin
                  if_ready = 1'b1;
                  if_rdata = mem_ack ? mem_rdata : DW'(ABORT_RDATA);
               end else begin
                  d_ready = 1'b1;
                  d_rdata = mem_ack ? mem_rdata : DW'(ABORT_RDATA);
               end
            end else begin
               wd_inc = 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Memory-side request registers, loaded from the winner at grant time.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         mem_req <= (state_next != IDLE);
         if (grant) begin
            if (grant_owner == OWNER_D) begin
               mem_we    <= d_we;
               mem_addr  <= d_addr;
               mem_wdata <= d_wdata;
            end else begin
               mem_we   <= 1'b0;
               mem_addr <= if_addr;
            end
         end
      end
   end

   // Consecutive data grants taken while a fetch was waiting.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dstreak <= 4'd0;
      end else if (grant) begin
         if (grant_owner == OWNER_I) begin
            dstreak <= 4'd0;
         end else if (if_req && !streak_full) begin
            dstreak <= dstreak + 4'd1;
         end
      end
   end

   // Sticky abort flag, cleared only by reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err <= 1'b0;
      end else if (set_err) begin
         err <= 1'b1;
      end
   end

   assign stall = (if_req & ~if_ready) | (d_req & ~d_ready);

endmodule
